// File: rtl/reservation_station_pkg.sv
// Shared rename/op widths and reservation-station entry layout.
// Imported by the RS, SLB and issue stage so field positions stay in sync.
package reservation_station_pkg;

    localparam int RS_SIZE_DEF  = 8;
    localparam int Q_WIDTH_DEF  = 5;
    localparam int OP_WIDTH_DEF = 8;
    localparam int DATA_W       = 32;

    // Packed entry layout, LSB first: vk | vj | npc | imm | dest | op
    localparam int ENT_VK_LSB   = 0;
    localparam int ENT_VJ_LSB   = ENT_VK_LSB + DATA_W;
    localparam int ENT_NPC_LSB  = ENT_VJ_LSB + DATA_W;
    localparam int ENT_IMM_LSB  = ENT_NPC_LSB + DATA_W;
    localparam int ENT_DEST_LSB = ENT_IMM_LSB + DATA_W;
    localparam int ENT_OP_LSB   = ENT_DEST_LSB + Q_WIDTH_DEF;
    localparam int ENT_W        = ENT_OP_LSB + OP_WIDTH_DEF;

endpackage

// File: rtl/reservation_station_select.sv
// Priority encoder: reports whether any request bit is set and the
// index of the lowest one.
module lowest_index_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: buffers issued ops, snoops the CDB for
// pending operands and dispatches the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int Q_WIDTH  = Q_WIDTH_DEF,
    parameter int OP_WIDTH = OP_WIDTH_DEF
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                flush_in,
    input  logic                issue_valid,
    input  logic [OP_WIDTH-1:0] issue_op,
    input  logic [DATA_W-1:0]   issue_imm,
    input  logic [DATA_W-1:0]   issue_npc,
    input  logic [Q_WIDTH-1:0]  issue_dest,
    input  logic [DATA_W-1:0]   issue_vj,
    input  logic [Q_WIDTH-1:0]  issue_qj,
    input  logic                issue_qj_busy,
    input  logic [DATA_W-1:0]   issue_vk,
    input  logic [Q_WIDTH-1:0]  issue_qk,
    input  logic                issue_qk_busy,
    input  logic                cdb_valid,
    input  logic [Q_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_W-1:0]   cdb_value,
    output logic                rs_full,
    output logic                alu_valid,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic [DATA_W-1:0]   alu_vj,
    output logic [DATA_W-1:0]   alu_vk,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [DATA_W-1:0]   alu_npc,
    output logic [Q_WIDTH-1:0]  alu_dest
);

    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  r_busy;
    logic [RS_SIZE-1:0]  r_qj_pend;
    logic [RS_SIZE-1:0]  r_qk_pend;
    logic [OP_WIDTH-1:0] r_op   [RS_SIZE];
    logic [DATA_W-1:0]   r_imm  [RS_SIZE];
    logic [DATA_W-1:0]   r_npc  [RS_SIZE];
    logic [Q_WIDTH-1:0]  r_dest [RS_SIZE];
    logic [DATA_W-1:0]   r_vj   [RS_SIZE];
    logic [DATA_W-1:0]   r_vk   [RS_SIZE];
    logic [Q_WIDTH-1:0]  r_qj   [RS_SIZE];
    logic [Q_WIDTH-1:0]  r_qk   [RS_SIZE];

    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_found;
    logic [IW-1:0]      w_free_idx;
    logic               w_disp_found;
    logic [IW-1:0]      w_disp_idx;
    logic               w_issue;
    logic               w_fwd_j;
    logic               w_fwd_k;

    assign rs_full = &r_busy;
    assign w_ready = r_busy & ~r_qj_pend & ~r_qk_pend;
    assign w_issue = issue_valid & ~rs_full & ~flush_in & w_free_found;
    assign w_fwd_j = issue_qj_busy & cdb_valid & (cdb_tag == issue_qj);
    assign w_fwd_k = issue_qk_busy & cdb_valid & (cdb_tag == issue_qk);

    lowest_index_select #(.N(RS_SIZE), .W(IW)) u_alloc_sel (
        .i_req   (~r_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    lowest_index_select #(.N(RS_SIZE), .W(IW)) u_disp_sel (
        .i_req   (w_ready),
        .o_found (w_disp_found),
        .o_idx   (w_disp_idx)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_qj_pend <= '0;
            r_qk_pend <= '0;
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_vj    <= '0;
            alu_vk    <= '0;
            alu_imm   <= '0;
            alu_npc   <= '0;
            alu_dest  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]   <= '0;
                r_imm[i]  <= '0;
                r_npc[i]  <= '0;
                r_dest[i] <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
            end
        end else if (flush_in) begin
            r_busy    <= '0;
            alu_valid <= 1'b0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_pend[i] && r_qj[i] == cdb_tag) begin
                        r_vj[i]      <= cdb_value;
                        r_qj_pend[i] <= 1'b0;
                    end
                    if (r_busy[i] && r_qk_pend[i] && r_qk[i] == cdb_tag) begin
                        r_vk[i]      <= cdb_value;
                        r_qk_pend[i] <= 1'b0;
                    end
                end
            end

            alu_valid <= w_disp_found;
            if (w_disp_found) begin
                alu_op             <= r_op[w_disp_idx];
                alu_vj             <= r_vj[w_disp_idx];
                alu_vk             <= r_vk[w_disp_idx];
                alu_imm            <= r_imm[w_disp_idx];
                alu_npc            <= r_npc[w_disp_idx];
                alu_dest           <= r_dest[w_disp_idx];
                r_busy[w_disp_idx] <= 1'b0;
            end

            // Free slot is never the dispatching one: that entry is still busy now.
            if (w_issue) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= issue_op;
                r_imm[w_free_idx]     <= issue_imm;
                r_npc[w_free_idx]     <= issue_npc;
                r_dest[w_free_idx]    <= issue_dest;
                r_qj[w_free_idx]      <= issue_qj;
                r_qk[w_free_idx]      <= issue_qk;
                r_vj[w_free_idx]      <= w_fwd_j ? cdb_value : issue_vj;
                r_vk[w_free_idx]      <= w_fwd_k ? cdb_value : issue_vk;
                r_qj_pend[w_free_idx] <= issue_qj_busy & ~w_fwd_j;
                r_qk_pend[w_free_idx] <= issue_qk_busy & ~w_fwd_k;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table, corner sequences and
// randomized traffic against a behavioural entry-pool model.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        flush_in;
    logic        issue_valid;
    logic [7:0]  issue_op;
    logic [31:0] issue_imm;
    logic [31:0] issue_npc;
    logic [4:0]  issue_dest;
    logic [31:0] issue_vj;
    logic [4:0]  issue_qj;
    logic        issue_qj_busy;
    logic [31:0] issue_vk;
    logic [4:0]  issue_qk;
    logic        issue_qk_busy;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        rs_full;
    logic        alu_valid;
    logic [7:0]  alu_op;
    logic [31:0] alu_vj;
    logic [31:0] alu_vk;
    logic [31:0] alu_imm;
    logic [31:0] alu_npc;
    logic [4:0]  alu_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    reservation_station dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .flush_in      (flush_in),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_imm     (issue_imm),
        .issue_npc     (issue_npc),
        .issue_dest    (issue_dest),
        .issue_vj      (issue_vj),
        .issue_qj      (issue_qj),
        .issue_qj_busy (issue_qj_busy),
        .issue_vk      (issue_vk),
        .issue_qk      (issue_qk),
        .issue_qk_busy (issue_qk_busy),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .rs_full       (rs_full),
        .alu_valid     (alu_valid),
        .alu_op        (alu_op),
        .alu_vj        (alu_vj),
        .alu_vk        (alu_vk),
        .alu_imm       (alu_imm),
        .alu_npc       (alu_npc),
        .alu_dest      (alu_dest)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush_in      = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = '0;
        issue_imm     = '0;
        issue_npc     = '0;
        issue_dest    = '0;
        issue_vj      = '0;
        issue_qj      = '0;
        issue_qj_busy = 1'b0;
        issue_vk      = '0;
        issue_qk      = '0;
        issue_qk_busy = 1'b0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_value     = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit          pj;
        bit          pk;
        logic [7:0]  op;
        logic [31:0] vj, vk, imm, npc;
        logic [4:0]  qj, qk, dest;
    } ment_t;

    ment_t       m [8];
    bit          mv;
    logic [7:0]  mop;
    logic [31:0] mvj, mvk, mimm, mnpc;
    logic [4:0]  mdest;

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m[i].busy = 0;
        mv = 0; mop = 0; mvj = 0; mvk = 0; mimm = 0; mnpc = 0; mdest = 0;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_edge();
        int d = -1;
        int f = -1;
        bit full = m_full();
        if (flush_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 0;
            mv = 0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (d < 0 && m[i].busy && !m[i].pj && !m[i].pk) d = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        mv = (d >= 0);
        if (d >= 0) begin
            mop = m[d].op; mvj = m[d].vj; mvk = m[d].vk;
            mimm = m[d].imm; mnpc = m[d].npc; mdest = m[d].dest;
            m[d].busy = 0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (!m[i].busy) continue;
                if (m[i].pj && m[i].qj == cdb_tag) begin m[i].vj = cdb_value; m[i].pj = 0; end
                if (m[i].pk && m[i].qk == cdb_tag) begin m[i].vk = cdb_value; m[i].pk = 0; end
            end
        end
        if (issue_valid && !full) begin
            bit fj = issue_qj_busy && cdb_valid && cdb_tag == issue_qj;
            bit fk = issue_qk_busy && cdb_valid && cdb_tag == issue_qk;
            m[f].busy = 1;
            m[f].op = issue_op; m[f].imm = issue_imm; m[f].npc = issue_npc;
            m[f].dest = issue_dest; m[f].qj = issue_qj; m[f].qk = issue_qk;
            m[f].vj = fj ? cdb_value : issue_vj;
            m[f].vk = fk ? cdb_value : issue_vk;
            m[f].pj = issue_qj_busy && !fj;
            m[f].pk = issue_qk_busy && !fk;
        end
    endfunction

    function automatic logic [4:0] rtag();
        logic [4:0] t = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) t = t | 5'h10;
        return t;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit          iv;
        logic [7:0]  op;
        logic [31:0] vj;
        bit          qjb;
        logic [4:0]  qj;
        logic [31:0] vk;
        bit          qkb;
        logic [4:0]  qk;
        logic [4:0]  dest;
        bit          cv;
        logic [4:0]  ct;
        logic [31:0] cval;
        bit          ev;
        logic [31:0] evj;
        logic [31:0] evk;
        logic [4:0]  ed;
    } vec_t;

    function automatic vec_t mk(bit iv, logic [7:0] op, logic [31:0] vj, bit qjb, logic [4:0] qj,
                                logic [31:0] vk, bit qkb, logic [4:0] qk, logic [4:0] dest,
                                bit cv, logic [4:0] ct, logic [31:0] cval,
                                bit ev, logic [31:0] evj, logic [31:0] evk, logic [4:0] ed);
        vec_t v;
        v.iv = iv; v.op = op; v.vj = vj; v.qjb = qjb; v.qj = qj;
        v.vk = vk; v.qkb = qkb; v.qk = qk; v.dest = dest;
        v.cv = cv; v.ct = ct; v.cval = cval;
        v.ev = ev; v.evj = evj; v.evk = evk; v.ed = ed;
        return v;
    endfunction

    vec_t vt [18];

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk("reset_valid", {159'b0, alu_valid}, 160'd0);
        chk("reset_full", {159'b0, rs_full}, 160'd0);
        tick();
        chk("reset_data", {alu_op, alu_vj, alu_vk, alu_imm, alu_npc, alu_dest},
            {8'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0});
        reset_dut();

        //          iv op     vj     qjb qj     vk   qkb qk    dest cv ct     cval          ev evj           evk    ed
        vt[0]  = mk(1, 8'h13, 5,     0, 0,     7,   0,  0,    3,   0, 0,     0,            0, 0,            0,     0);
        vt[1]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            1, 5,            7,     3);
        vt[2]  = mk(1, 8'h33, 0,     1, 9,     1,   0,  0,    4,   0, 0,     0,            0, 5,            7,     3);
        vt[3]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            0, 5,            7,     3);
        vt[4]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            0, 5,            7,     3);
        vt[5]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   1, 9,     32'hDEAD,     0, 5,            7,     3);
        vt[6]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            1, 32'hDEAD,     1,     4);
        vt[7]  = mk(1, 8'h01, 11,    0, 0,     0,   1,  2,    5,   1, 2,     42,           0, 32'hDEAD,     1,     4);
        vt[8]  = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            1, 11,           42,    5);
        vt[9]  = mk(1, 8'h02, 0,     1, 7,     0,   1,  7,    6,   0, 0,     0,            0, 11,           42,    5);
        vt[10] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   1, 7,     32'h77,       0, 11,           42,    5);
        vt[11] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            1, 32'h77,       32'h77, 6);
        vt[12] = mk(1, 8'h03, 0,     1, 5'h11, 2,   0,  0,    7,   0, 0,     0,            0, 32'h77,       32'h77, 6);
        vt[13] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   1, 5'h01, 1,            0, 32'h77,       32'h77, 6);
        vt[14] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            0, 32'h77,       32'h77, 6);
        vt[15] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   1, 5'h11, 32'h55,       0, 32'h77,       32'h77, 6);
        vt[16] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            1, 32'h55,       2,     7);
        vt[17] = mk(0, 0,     0,     0, 0,     0,   0,  0,    0,   0, 0,     0,            0, 32'h55,       2,     7);

        for (int i = 0; i < 18; i++) begin
            idle();
            issue_valid = vt[i].iv; issue_op = vt[i].op; issue_dest = vt[i].dest;
            issue_vj = vt[i].vj; issue_qj_busy = vt[i].qjb; issue_qj = vt[i].qj;
            issue_vk = vt[i].vk; issue_qk_busy = vt[i].qkb; issue_qk = vt[i].qk;
            cdb_valid = vt[i].cv; cdb_tag = vt[i].ct; cdb_value = vt[i].cval;
            tick();
            chk($sformatf("vec%0d_valid", i), {159'b0, alu_valid}, {159'b0, vt[i].ev});
            chk($sformatf("vec%0d_full", i), {159'b0, rs_full}, 160'd0);
            chk($sformatf("vec%0d_data", i), {alu_vj, alu_vk, alu_dest},
                {vt[i].evj, vt[i].evk, vt[i].ed});
        end

        // Fill all entries waiting on tag 1, then release them with one broadcast.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            idle();
            issue_valid = 1; issue_qj_busy = 1; issue_qj = 5'd1;
            issue_vk = 32'(i); issue_dest = 5'(i); issue_op = 8'(i);
            tick();
        end
        chk("full_set", {159'b0, rs_full}, 160'd1);
        issue_dest = 5'd20;
        tick();
        chk("full_9th_full", {159'b0, rs_full}, 160'd1);
        chk("full_9th_valid", {159'b0, alu_valid}, 160'd0);
        idle();
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'd100;
        tick();
        chk("full_nobypass", {159'b0, alu_valid}, 160'd0);
        idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("full_disp%0d", i), {alu_valid, alu_dest, alu_vj, alu_vk},
                {1'b1, 5'(i), 32'd100, 32'(i)});
            if (i == 0) chk("full_clear", {159'b0, rs_full}, 160'd0);
        end
        tick();
        chk("full_drained", {159'b0, alu_valid}, 160'd0);

        // Flush with busy entries, a ready entry, issue and CDB all active.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            idle();
            issue_valid = 1; issue_dest = 5'(i);
            issue_qj_busy = (i < 3); issue_qj = 5'd3;
            tick();
        end
        chk("flush_pre", {159'b0, alu_valid}, 160'd0);
        idle();
        flush_in = 1; issue_valid = 1; issue_dest = 5'd10;
        cdb_valid = 1; cdb_tag = 5'd3; cdb_value = 32'd5;
        tick();
        chk("flush_valid", {159'b0, alu_valid}, 160'd0);
        chk("flush_full", {159'b0, rs_full}, 160'd0);
        idle();
        cdb_valid = 1; cdb_tag = 5'd3; cdb_value = 32'd6;
        for (int i = 0; i < 6; i++) begin
            tick();
            idle();
            chk($sformatf("flush_after%0d", i), {159'b0, alu_valid}, 160'd0);
        end

        // Randomized traffic against the model.
        reset_dut();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            idle();
            issue_valid   = ($urandom_range(0, 2) != 0);
            issue_op      = 8'($urandom);
            issue_imm     = $urandom;
            issue_npc     = $urandom;
            issue_dest    = 5'($urandom);
            issue_vj      = $urandom;
            issue_vk      = $urandom;
            issue_qj_busy = $urandom_range(0, 1) == 1;
            issue_qk_busy = $urandom_range(0, 2) == 0;
            issue_qj      = rtag();
            issue_qk      = rtag();
            cdb_valid     = $urandom_range(0, 9) < 4;
            cdb_tag       = rtag();
            cdb_value     = $urandom;
            flush_in      = $urandom_range(0, 59) == 0;
            m_edge();
            tick();
            chk("rnd_full", {159'b0, rs_full}, {159'b0, m_full()});
            chk("rnd_valid", {159'b0, alu_valid}, {159'b0, mv});
            chk("rnd_data", {alu_op, alu_vj, alu_vk, alu_imm, alu_npc, alu_dest},
                {mop, mvj, mvk, mimm, mnpc, mdest});
        end

        // Async reset mid-traffic.
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_rnd_full", {159'b0, rs_full}, 160'd0);
        chk("areset_rnd_valid", {159'b0, alu_valid}, 160'd0);
        reset_dut();
        issue_valid = 1; issue_dest = 5'd1; issue_vj = 32'd1;
        tick();
        issue_dest = 5'd2; issue_vj = 32'd2;
        tick();
        chk("areset_pre", {alu_valid, alu_dest}, {1'b1, 5'd1});
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", {159'b0, alu_valid}, 160'd0);
        chk("areset_full", {159'b0, rs_full}, 160'd0);
        chk("areset_data", {alu_vj, alu_dest}, {32'd0, 5'd0});
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("areset_after%0d", i), {159'b0, alu_valid}, 160'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
